alu_64: RTL and testbench

ALU_64 -- requirements
Module: alu_64

---
 rtl/alu_pkg.sv | 19 +
 rtl/alu_core.sv | 53 +++++
 rtl/alu_64.sv | 44 ++++
 tb/tb_alu_64.sv | 228 ++++++++++++++++++++++
 4 files changed

// File: rtl/alu_pkg.sv
// Shared constants for the 64-bit ALU: datapath width, shift-amount width and opcodes.
package alu_pkg;
  localparam int WIDTH   = 64;
  localparam int SHAMT_W = 6;

  typedef enum logic [3:0] {
    OP_AND  = 4'b0000,
    OP_OR   = 4'b0001,
    OP_ADD  = 4'b0010,
    OP_XOR  = 4'b0011,
    OP_SLL  = 4'b0100,
    OP_SRL  = 4'b0101,
    OP_SUB  = 4'b0110,
    OP_SLT  = 4'b0111,
    OP_SRA  = 4'b1000,
    OP_SLTU = 4'b1001,
    OP_NOR  = 4'b1100
  } alu_op_e;
endpackage

// File: rtl/alu_core.sv
// Combinational ALU datapath; ADD/SUB/SLT/SLTU all share a single adder.
module alu_core #(
  parameter int WIDTH = alu_pkg::WIDTH
) (
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic [3:0]       OP,
  output logic [WIDTH-1:0] result,
  output logic             overflow
);
  import alu_pkg::*;

  localparam int MSB = WIDTH - 1;

  logic               w_sub;
  logic [WIDTH-1:0]   w_b_eff;
  logic [WIDTH-1:0]   w_sum;
  logic               w_cout;
  logic               w_v;
  logic               w_lt_s;
  logic               w_lt_u;
  logic [SHAMT_W-1:0] w_shamt;

  // Everything except ADD runs the adder as A + ~B + 1.
  assign w_sub   = (OP != OP_ADD);
  assign w_b_eff = w_sub ? ~B : B;
  assign {w_cout, w_sum} = {1'b0, A} + {1'b0, w_b_eff} + {{WIDTH{1'b0}}, w_sub};

  assign w_v     = (A[MSB] == w_b_eff[MSB]) && (w_sum[MSB] != A[MSB]);
  // Sign of the difference corrected by overflow gives the exact signed compare.
  assign w_lt_s  = w_sum[MSB] ^ w_v;
  assign w_lt_u  = ~w_cout;
  assign w_shamt = B[SHAMT_W-1:0];

  always_comb begin
    result   = '0;
    overflow = 1'b0;
    case (alu_op_e'(OP))
      OP_AND:  result = A & B;
      OP_OR:   result = A | B;
      OP_XOR:  result = A ^ B;
      OP_NOR:  result = ~(A | B);
      OP_ADD:  begin result = w_sum; overflow = w_v; end
      OP_SUB:  begin result = w_sum; overflow = w_v; end
      OP_SLT:  result = {{(WIDTH-1){1'b0}}, w_lt_s};
      OP_SLTU: result = {{(WIDTH-1){1'b0}}, w_lt_u};
      OP_SLL:  result = A << w_shamt;
      OP_SRL:  result = A >> w_shamt;
      OP_SRA:  result = WIDTH'($signed(A) >>> w_shamt);
      default: ;
    endcase
  end
endmodule

// File: rtl/alu_64.sv
// Single-cycle registered ALU: combinational core followed by output registers.
module alu_64 #(
  parameter int WIDTH = alu_pkg::WIDTH
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic [3:0]       OP,
  output logic [WIDTH-1:0] O,
  output logic             Ovf,
  output logic             Zero
);
  logic [WIDTH-1:0] w_res;
  logic             w_ovf;
  logic [WIDTH-1:0] r_o;
  logic             r_ovf;
  logic             r_zero;

  alu_core #(.WIDTH(WIDTH)) u_core (
    .A        (A),
    .B        (B),
    .OP       (OP),
    .result   (w_res),
    .overflow (w_ovf)
  );

  // Zero is registered from the same value loaded into r_o so the two always agree.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_o    <= '0;
      r_ovf  <= 1'b0;
      r_zero <= 1'b1;
    end else begin
      r_o    <= w_res;
      r_ovf  <= w_ovf;
      r_zero <= ~|w_res;
    end
  end

  assign O    = r_o;
  assign Ovf  = r_ovf;
  assign Zero = r_zero;
endmodule

// File: tb/tb_alu_64.sv
// Self-checking bench for alu_64: directed cases plus randomized ops against a behavioural model.
module tb_alu_64;
  logic        clk;
  logic        rst;
  logic [63:0] A, B;
  logic [3:0]  OP;
  logic [63:0] O;
  logic        Ovf, Zero;

  int errors = 0;
  int checks = 0;

  alu_64 dut (
    .clk  (clk),
    .rst  (rst),
    .A    (A),
    .B    (B),
    .OP   (OP),
    .O    (O),
    .Ovf  (Ovf),
    .Zero (Zero)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference computed from the arithmetic meaning of each op.
  function automatic void ref_alu(input logic [63:0] a, input logic [63:0] b,
                                  input logic [3:0] op,
                                  output logic [63:0] o, output logic ovf);
    logic signed [65:0] s;
    int unsigned sh;
    o   = '0;
    ovf = 1'b0;
    sh  = int'(b % 64);
    case (op)
      4'b0000: o = a & b;
      4'b0001: o = a | b;
      4'b0011: o = a ^ b;
      4'b1100: o = ~(a | b);
      4'b0010: begin
        o = a + b;
        s = $signed({{2{a[63]}}, a}) + $signed({{2{b[63]}}, b});
        ovf = (s != $signed({{2{o[63]}}, o}));
      end
      4'b0110: begin
        o = a - b;
        s = $signed({{2{a[63]}}, a}) - $signed({{2{b[63]}}, b});
        ovf = (s != $signed({{2{o[63]}}, o}));
      end
      4'b0111: o = ($signed(a) < $signed(b)) ? 64'd1 : 64'd0;
      4'b1001: o = (a < b) ? 64'd1 : 64'd0;
      4'b0100: o = a << sh;
      4'b0101: o = a >> sh;
      4'b1000: o = 64'($signed(a) >>> sh);
      default: o = '0;
    endcase
  endfunction

  task automatic drive(input logic [63:0] a, input logic [63:0] b, input logic [3:0] op);
    A = a; B = b; OP = op;
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1; A = 64'h1234; B = 64'h5; OP = 4'b0010;
    #3;
    checks++;
    if (O !== 64'd0 || Ovf !== 1'b0 || Zero !== 1'b1) begin
      errors++;
      $display("FAIL reset_async: O=%h Ovf=%b Zero=%b want 0/0/1", O, Ovf, Zero);
    end
    drive(64'h7fffffffffffffff, 64'd1, 4'b0010);
    checks++;
    if (O !== 64'd0 || Ovf !== 1'b0 || Zero !== 1'b1) begin
      errors++;
      $display("FAIL reset_held: O=%h Ovf=%b Zero=%b want 0/0/1", O, Ovf, Zero);
    end
    rst = 1'b0;
  endtask

  task automatic test_arith();
    drive(64'd7, 64'd5, 4'b0010);
    checks++;
    if (O !== 64'd12 || Ovf !== 1'b0 || Zero !== 1'b0) begin
      errors++;
      $display("FAIL add_7_5: O=%h Ovf=%b Zero=%b want 12/0/0", O, Ovf, Zero);
    end
    drive(64'd5, 64'd5, 4'b0110);
    checks++;
    if (O !== 64'd0 || Ovf !== 1'b0 || Zero !== 1'b1) begin
      errors++;
      $display("FAIL sub_5_5: O=%h Ovf=%b Zero=%b want 0/0/1", O, Ovf, Zero);
    end
    drive(64'h7fffffffffffffff, 64'd1, 4'b0010);
    checks++;
    if (O !== 64'h8000000000000000 || Ovf !== 1'b1 || Zero !== 1'b0) begin
      errors++;
      $display("FAIL add_ovf: O=%h Ovf=%b Zero=%b want 8000000000000000/1/0", O, Ovf, Zero);
    end
    drive(64'h8000000000000000, 64'd1, 4'b0110);
    checks++;
    if (O !== 64'h7fffffffffffffff || Ovf !== 1'b1) begin
      errors++;
      $display("FAIL sub_ovf: O=%h Ovf=%b want 7fffffffffffffff/1", O, Ovf);
    end
    drive(64'h8000000000000000, 64'd1, 4'b0111);
    checks++;
    if (O !== 64'd1 || Ovf !== 1'b0 || Zero !== 1'b0) begin
      errors++;
      $display("FAIL slt_min: O=%h Ovf=%b Zero=%b want 1/0/0", O, Ovf, Zero);
    end
    drive(64'h8000000000000000, 64'd1, 4'b1001);
    checks++;
    if (O !== 64'd0 || Ovf !== 1'b0 || Zero !== 1'b1) begin
      errors++;
      $display("FAIL sltu_min: O=%h Ovf=%b Zero=%b want 0/0/1", O, Ovf, Zero);
    end
    drive(64'h7fffffffffffffff, 64'hffffffffffffffff, 4'b0111);
    checks++;
    if (O !== 64'd0) begin
      errors++;
      $display("FAIL slt_overflowing: O=%h want 0", O);
    end
  endtask

  task automatic test_shifts();
    drive(64'h8000000000000000, 64'h43, 4'b1000);
    checks++;
    if (O !== 64'hf000000000000000 || Ovf !== 1'b0) begin
      errors++;
      $display("FAIL sra_3: O=%h Ovf=%b want f000000000000000/0", O, Ovf);
    end
    drive(64'h8000000000000000, 64'h43, 4'b0101);
    checks++;
    if (O !== 64'h1000000000000000) begin
      errors++;
      $display("FAIL srl_3: O=%h want 1000000000000000", O);
    end
    drive(64'h8000000000000000, 64'h43, 4'b0100);
    checks++;
    if (O !== 64'd0 || Zero !== 1'b1) begin
      errors++;
      $display("FAIL sll_3: O=%h Zero=%b want 0/1", O, Zero);
    end
    drive(64'hdeadbeef00000001, 64'hffffffffffffffc0, 4'b0100);
    checks++;
    if (O !== 64'hdeadbeef00000001) begin
      errors++;
      $display("FAIL shift_zero_amt: O=%h want deadbeef00000001", O);
    end
  endtask

  task automatic test_back_to_back();
    logic [3:0]  ops  [5] = '{4'b0000, 4'b0001, 4'b0011, 4'b1100, 4'b1111};
    logic [63:0] want [5] = '{64'hf000, 64'hfff0, 64'h0ff0, 64'hffffffffffff000f, 64'd0};
    for (int i = 0; i < 5; i++) begin
      drive(64'hf0f0, 64'hff00, ops[i]);
      checks++;
      if (O !== want[i] || Ovf !== 1'b0 || Zero !== (want[i] == 64'd0)) begin
        errors++;
        $display("FAIL b2b_op%0d: O=%h Ovf=%b Zero=%b want %h/0/%b",
                 i, O, Ovf, Zero, want[i], (want[i] == 64'd0));
      end
    end
  endtask

  task automatic test_random();
    logic [63:0] a, b, eo;
    logic [3:0]  op;
    logic        eovf;
    for (int i = 0; i < 400; i++) begin
      a  = {$urandom, $urandom};
      b  = {$urandom, $urandom};
      op = 4'($urandom_range(0, 15));
      case ($urandom_range(0, 5))
        0: b = a;
        1: a = {~a[63], 63'($urandom_range(0, 3))};
        2: b = {b[63], 63'h7fffffffffffffff};
        default: ;
      endcase
      ref_alu(a, b, op, eo, eovf);
      drive(a, b, op);
      checks++;
      if (O !== eo || Ovf !== eovf || Zero !== (eo == 64'd0)) begin
        errors++;
        $display("FAIL rand_op%b: A=%h B=%h O=%h Ovf=%b Zero=%b want %h/%b/%b",
                 op, a, b, O, Ovf, Zero, eo, eovf, (eo == 64'd0));
      end
    end
  endtask

  task automatic test_async_reset();
    drive(64'h7fffffffffffffff, 64'd1, 4'b0010);
    #2 rst = 1'b1;
    #1;
    checks++;
    if (O !== 64'd0 || Ovf !== 1'b0 || Zero !== 1'b1) begin
      errors++;
      $display("FAIL rst_midcycle: O=%h Ovf=%b Zero=%b want 0/0/1", O, Ovf, Zero);
    end
    drive(64'd9, 64'd9, 4'b0001);
    checks++;
    if (O !== 64'd0 || Zero !== 1'b1) begin
      errors++;
      $display("FAIL rst_discard: O=%h Zero=%b want 0/1", O, Zero);
    end
    rst = 1'b0;
    drive(64'd7, 64'd5, 4'b0010);
    checks++;
    if (O !== 64'd12 || Ovf !== 1'b0 || Zero !== 1'b0) begin
      errors++;
      $display("FAIL post_rst_add: O=%h Ovf=%b Zero=%b want 12/0/0", O, Ovf, Zero);
    end
  endtask

  initial begin
    test_reset();
    test_arith();
    test_shifts();
    test_back_to_back();
    test_random();
    test_async_reset();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
